// File: rtl/slc3_control_pw.sv
// SLC-3 instruction sequencer: fetch, decode and execute control for the SLC-3 datapath.
// A single wait counter stretches every memory access (fetch, load, store) to MEM_WAIT cycles.
module slc3_control_pw #(
   parameter int MEM_WAIT = 3,
   parameter int PAUSE_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic        ben,
   input  logic        run_i,
   input  logic        continue_i,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_pc,
   output logic        ld_led,
   output logic        ld_ben,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic [3:0]  bus_sel,
   output logic        mdr_sel,
   output logic [1:0]  pcmux,
   output logic        addr1_sel,
   output logic [1:0]  addr2_sel,
   output logic        sr1_sel,
   output logic        dr_sel,
   output logic        sr2_sel,
   output logic [1:0]  aluk,
   output logic        mem_ena,
   output logic        mem_wr_ena,
   output logic        halted_o
);

   typedef enum logic [4:0] {
      S_HALTED    = 5'd0,
      S_FETCH     = 5'd1,
      S_FETCH_MEM = 5'd2,
      S_FETCH_IR  = 5'd3,
      S_DECODE    = 5'd4,
      S_ADD       = 5'd5,
      S_AND       = 5'd6,
      S_NOT       = 5'd7,
      S_LDR_ADDR  = 5'd8,
      S_LDR_MEM   = 5'd9,
      S_LDR_WB    = 5'd10,
      S_STR_ADDR  = 5'd11,
      S_STR_DATA  = 5'd12,
      S_STR_MEM   = 5'd13,
      S_JSR_LINK  = 5'd14,
      S_JSR_JUMP  = 5'd15,
      S_JMP       = 5'd16,
      S_BR        = 5'd17,
      S_BR_TAKE   = 5'd18,
      S_PAUSE1    = 5'd19,
      S_PAUSE2    = 5'd20
   } state_e;

   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_led;
      logic       ld_ben;
      logic       ld_reg;
      logic       ld_cc;
      logic [3:0] bus_sel;
      logic       mdr_sel;
      logic [1:0] pcmux;
      logic       addr1_sel;
      logic [1:0] addr2_sel;
      logic       sr1_sel;
      logic       dr_sel;
      logic [1:0] aluk;
      logic       mem_ena;
      logic       mem_wr_ena;
      logic       halted;
   } ctrl_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   ctrl_t       ctrl_q;
   logic        wait_done_s;
   logic        ir_unused_s;

   assign ir_unused_s = ^{ir[10:6], ir[4:0]};

   function automatic ctrl_t halted_ctrl();
      ctrl_t c;
      c = '0;
      c.halted = 1'b1;
      return c;
   endfunction

   // Control word for a state; evaluated on the next state so outputs come straight from flops
   function automatic ctrl_t decode_ctrl(input state_e st, input logic jsr_imm);
      ctrl_t c;
      c = '0;
      case (st)
         S_HALTED: c.halted = 1'b1;
         S_FETCH: begin
            c.bus_sel = 4'b0100;
            c.ld_mar  = 1'b1;
            c.ld_pc   = 1'b1;
            c.pcmux   = 2'b00;
         end
         S_FETCH_MEM, S_LDR_MEM: begin
            c.mem_ena = 1'b1;
            c.ld_mdr  = 1'b1;
            c.mdr_sel = 1'b1;
         end
         S_FETCH_IR: begin
            c.bus_sel = 4'b0001;
            c.ld_ir   = 1'b1;
         end
         S_DECODE: c.ld_ben = 1'b1;
         S_ADD, S_AND, S_NOT: begin
            c.sr1_sel = 1'b1;
            c.bus_sel = 4'b0010;
            c.ld_reg  = 1'b1;
            c.ld_cc   = 1'b1;
            c.aluk    = (st == S_ADD) ? 2'b00 : ((st == S_AND) ? 2'b01 : 2'b10);
         end
         S_LDR_ADDR, S_STR_ADDR: begin
            c.sr1_sel   = 1'b1;
            c.addr1_sel = 1'b1;
            c.addr2_sel = 2'b01;
            c.bus_sel   = 4'b1000;
            c.ld_mar    = 1'b1;
         end
         S_LDR_WB: begin
            c.bus_sel = 4'b0001;
            c.ld_reg  = 1'b1;
            c.ld_cc   = 1'b1;
         end
         S_STR_DATA: begin
            c.aluk    = 2'b11;
            c.bus_sel = 4'b0010;
            c.ld_mdr  = 1'b1;
         end
         S_STR_MEM: begin
            c.mem_ena    = 1'b1;
            c.mem_wr_ena = 1'b1;
         end
         S_JSR_LINK: begin
            c.bus_sel = 4'b0100;
            c.dr_sel  = 1'b1;
            c.ld_reg  = 1'b1;
         end
         S_JSR_JUMP: begin
            c.ld_pc = 1'b1;
            c.pcmux = 2'b10;
            if (jsr_imm) begin
               c.addr2_sel = 2'b11;
            end else begin
               c.sr1_sel   = 1'b1;
               c.addr1_sel = 1'b1;
            end
         end
         S_JMP: begin
            c.sr1_sel   = 1'b1;
            c.addr1_sel = 1'b1;
            c.pcmux     = 2'b10;
            c.ld_pc     = 1'b1;
         end
         S_BR: c = '0;
         S_BR_TAKE: begin
            c.addr2_sel = 2'b10;
            c.pcmux     = 2'b10;
            c.ld_pc     = 1'b1;
         end
         S_PAUSE1, S_PAUSE2: c.ld_led = 1'b1;
         default: c = halted_ctrl();
      endcase
      return c;
   endfunction

   assign wait_done_s = (cnt_q == WAIT_LAST);

   // Next-state and wait-counter logic; the counter is zero in every non-memory state
   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      case (state_q)
         S_HALTED: begin
            if (run_i) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_HALTED;
            end
         end
         S_FETCH: state_d = S_FETCH_MEM;
         S_FETCH_MEM, S_LDR_MEM, S_STR_MEM: begin
            if (wait_done_s) begin
               case (state_q)
                  S_FETCH_MEM: state_d = S_FETCH_IR;
                  S_LDR_MEM:   state_d = S_LDR_WB;
                  default:     state_d = S_FETCH;
               endcase
            end else begin
               cnt_d   = cnt_q + 4'd1;
               state_d = state_q;
            end
         end
         S_FETCH_IR: state_d = S_DECODE;
         S_DECODE: begin
            case (ir[15:12])
               4'b0001: state_d = S_ADD;
               4'b0101: state_d = S_AND;
               4'b1001: state_d = S_NOT;
               4'b0110: state_d = S_LDR_ADDR;
               4'b0111: state_d = S_STR_ADDR;
               4'b0100: state_d = S_JSR_LINK;
               4'b1100: state_d = S_JMP;
               4'b0000: state_d = S_BR;
               4'b1101: state_d = (PAUSE_EN != 0) ? S_PAUSE1 : S_FETCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_ADD, S_AND, S_NOT, S_LDR_WB, S_JSR_JUMP, S_JMP, S_BR_TAKE: state_d = S_FETCH;
         S_LDR_ADDR: state_d = S_LDR_MEM;
         S_STR_ADDR: state_d = S_STR_DATA;
         S_STR_DATA: state_d = S_STR_MEM;
         S_JSR_LINK: state_d = S_JSR_JUMP;
         S_BR: begin
            if (ben) begin
               state_d = S_BR_TAKE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_PAUSE1: begin
            if (continue_i) begin
               state_d = S_PAUSE2;
            end else begin
               state_d = S_PAUSE1;
            end
         end
         S_PAUSE2: begin
            if (!continue_i) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_PAUSE2;
            end
         end
         default: state_d = S_HALTED;
      endcase
   end

   // State, wait counter and registered control word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_HALTED;
         cnt_q   <= 4'd0;
         ctrl_q  <= halted_ctrl();
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= decode_ctrl(state_d, ir[11]);
      end
   end

   assign ld_mar     = ctrl_q.ld_mar;
   assign ld_mdr     = ctrl_q.ld_mdr;
   assign ld_ir      = ctrl_q.ld_ir;
   assign ld_pc      = ctrl_q.ld_pc;
   assign ld_led     = ctrl_q.ld_led;
   assign ld_ben     = ctrl_q.ld_ben;
   assign ld_reg     = ctrl_q.ld_reg;
   assign ld_cc      = ctrl_q.ld_cc;
   assign bus_sel    = ctrl_q.bus_sel;
   assign mdr_sel    = ctrl_q.mdr_sel;
   assign pcmux      = ctrl_q.pcmux;
   assign addr1_sel  = ctrl_q.addr1_sel;
   assign addr2_sel  = ctrl_q.addr2_sel;
   assign sr1_sel    = ctrl_q.sr1_sel;
   assign dr_sel     = ctrl_q.dr_sel;
   assign aluk       = ctrl_q.aluk;
   assign mem_ena    = ctrl_q.mem_ena;
   assign mem_wr_ena = ctrl_q.mem_wr_ena;
   assign halted_o   = ctrl_q.halted;

   // SR2 mux follows the immediate flag of the live instruction while an ADD/AND executes
   assign sr2_sel = ((state_q == S_ADD) || (state_q == S_AND)) ? ir[5] : 1'b0;

endmodule
